// File: rtl/tile_mem_pkg.sv
// Shared constants and helpers for the tile SRAM banks and their arbiter.
package tile_mem_pkg;

    // Geometry of the tile memory: four banks of 8 KiB, 64-bit accesses.
    localparam int TILE_BANKS      = 4;
    localparam int TILE_ADDR_WIDTH = 13;
    localparam int TILE_DATA_WIDTH = 64;
    localparam int TILE_SEL_W      = 2;

    // A tile address is the bank select on top of the in-bank byte address.
    localparam int TILE_REQ_ADDR_W = TILE_ADDR_WIDTH + TILE_SEL_W;

    // Kind of access carried on the bank write strobe.
    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } access_e;

    // Extract the bank index from a full tile byte address.
    function automatic logic [TILE_SEL_W-1:0] bank_of(input logic [TILE_REQ_ADDR_W-1:0] addr);
        return addr[TILE_REQ_ADDR_W-1 -: TILE_SEL_W];
    endfunction

endpackage

// File: rtl/tile_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter for one SRAM bank: one-hot grant, rotating priority pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Pick the first requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int cand;
        cand        = 0;
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (enable) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = int'(ptr_q) + i;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!grant_valid && req[cand[IDX_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[IDX_W-1:0];
                end
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Move priority to the requester just after the winner; hold when nothing was granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            if (grant_idx == LAST_IDX) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tile_bank_arbiter.sv
// Shares the tile SRAM banks between PE ports and the NoC port, returns read data
// one cycle after the grant, and counts denied request-cycles.
module tile_bank_arbiter
    import tile_mem_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int BANKS      = TILE_BANKS,
    parameter int ADDR_WIDTH = TILE_ADDR_WIDTH,
    parameter int DATA_WIDTH = TILE_DATA_WIDTH,
    parameter int SEL_W      = TILE_SEL_W,
    parameter int CNT_W      = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*(ADDR_WIDTH+SEL_W)-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]      rsp_rdata,
    output logic [BANKS-1:0]                   bank_enable,
    output logic [BANKS-1:0]                   bank_write_en,
    output logic [BANKS*ADDR_WIDTH-1:0]        bank_addr,
    output logic [BANKS*DATA_WIDTH-1:0]        bank_wdata,
    input  logic [BANKS*DATA_WIDTH-1:0]        bank_rdata,
    input  logic [BANKS-1:0]                   bank_ready,
    output logic [CNT_W-1:0]                   conflict_cnt
);

    localparam int                 REQ_AW  = ADDR_WIDTH + SEL_W;
    localparam int                 IDX_W   = $clog2(NUM_REQ);
    localparam int                 SUM_W   = CNT_W + 4;
    localparam logic [SUM_W-1:0]   CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [SEL_W-1:0]   req_bank [NUM_REQ];
    logic [NUM_REQ-1:0] bank_cand [BANKS];
    logic [NUM_REQ-1:0] bank_grant [BANKS];
    logic [IDX_W-1:0]   bank_grant_idx [BANKS];
    logic [BANKS-1:0]   bank_grant_valid;

    logic               armed_q;
    logic               armed_d;
    logic [NUM_REQ-1:0] rsp_pend_q;
    logic [NUM_REQ-1:0] rsp_pend_d;
    logic [SEL_W-1:0]   rsp_bank_q [NUM_REQ];
    logic [SEL_W-1:0]   rsp_bank_d [NUM_REQ];
    logic [CNT_W-1:0]   conflict_cnt_q;
    logic [CNT_W-1:0]   conflict_cnt_d;

    // Decode each requester's bank and build the candidate vector seen by every bank.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_bank[r] = req_addr[r*REQ_AW + ADDR_WIDTH +: SEL_W];
        end
        for (int b = 0; b < BANKS; b++) begin
            bank_cand[b] = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                bank_cand[b][r] = req_valid[r] && (req_bank[r] == SEL_W'(b));
            end
        end
    end

    // One arbiter per bank; a bank only grants once armed and while the SRAM is ready.
    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        rr_arbiter #(
            .NUM_REQ (NUM_REQ)
        ) u_rr_arbiter (
            .clk         (clk),
            .rst_n       (rst_n),
            .req         (bank_cand[g]),
            .enable      (armed_q & bank_ready[g]),
            .grant       (bank_grant[g]),
            .grant_valid (bank_grant_valid[g]),
            .grant_idx   (bank_grant_idx[g])
        );
    end

    // A requester is accepted when any bank granted it; it can win at most one bank.
    always_comb begin
        req_ready = '0;
        for (int b = 0; b < BANKS; b++) begin
            req_ready = req_ready | bank_grant[b];
        end
    end

    // Drive each bank from its winner; idle banks present an all-zero bus.
    always_comb begin
        bank_enable   = '0;
        bank_write_en = '0;
        bank_addr     = '0;
        bank_wdata    = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (bank_grant_valid[b]) begin
                bank_enable[b]   = 1'b1;
                bank_write_en[b] = req_write[bank_grant_idx[b]];
                bank_addr[b*ADDR_WIDTH +: ADDR_WIDTH] =
                    req_addr[int'(bank_grant_idx[b])*REQ_AW +: ADDR_WIDTH];
                bank_wdata[b*DATA_WIDTH +: DATA_WIDTH] =
                    req_wdata[int'(bank_grant_idx[b])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Remember which bank each granted read went to so its data can be returned next cycle.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            rsp_pend_d[r] = req_ready[r] && !req_write[r];
            rsp_bank_d[r] = req_bank[r];
        end
    end

    // Steer registered bank data to the requesters with a pending read; others see zero.
    always_comb begin
        rsp_valid = rsp_pend_q;
        rsp_rdata = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (rsp_pend_q[r]) begin
                rsp_rdata[r*DATA_WIDTH +: DATA_WIDTH] =
                    bank_rdata[int'(rsp_bank_q[r])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Add this cycle's denied requests to the conflict counter, saturating at all-ones.
    always_comb begin
        logic [3:0]       n_conf;
        logic [SUM_W-1:0] sum;
        n_conf = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (armed_q && req_valid[r] && !req_ready[r]) begin
                n_conf = n_conf + 4'd1;
            end
        end
        sum = SUM_W'(conflict_cnt_q) + SUM_W'(n_conf);
        if (sum > CNT_MAX) begin
            conflict_cnt_d = {CNT_W{1'b1}};
        end else begin
            conflict_cnt_d = sum[CNT_W-1:0];
        end
    end

    // The first edge after reset release arms the arbiters.
    always_comb begin
        armed_d = 1'b1;
    end

    assign conflict_cnt = conflict_cnt_q;

    // State registers; reset drops any in-flight read response and clears the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q        <= 1'b0;
            rsp_pend_q     <= '0;
            conflict_cnt_q <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                rsp_bank_q[r] <= '0;
            end
        end else begin
            armed_q        <= armed_d;
            rsp_pend_q     <= rsp_pend_d;
            conflict_cnt_q <= conflict_cnt_d;
            for (int r = 0; r < NUM_REQ; r++) begin
                rsp_bank_q[r] <= rsp_bank_d[r];
            end
        end
    end

endmodule
